// File: rtl/mult_share_arbiter_if.sv
// Handshake and multiplier bus between two requesters, the shared-multiplier
// arbiter, the external array multiplier and the response consumer.
interface mult_share_arbiter_if #(parameter int N = 4);
  logic           req0_valid, req0_ready;
  logic [N-1:0]   req0_m, req0_q;
  logic           req1_valid, req1_ready;
  logic [N-1:0]   req1_m, req1_q;
  logic [N-1:0]   mult_m, mult_q;
  logic [2*N-1:0] mult_p;
  logic           rsp_valid, rsp_ready, rsp_id;
  logic [2*N-1:0] rsp_p;

  modport slave (
    input  req0_valid, req0_m, req0_q, req1_valid, req1_m, req1_q, mult_p, rsp_ready,
    output req0_ready, req1_ready, mult_m, mult_q, rsp_valid, rsp_id, rsp_p
  );

  modport master (
    output req0_valid, req0_m, req0_q, req1_valid, req1_m, req1_q, mult_p, rsp_ready,
    input  req0_ready, req1_ready, mult_m, mult_q, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one external combinational array multiplier
// between two requesters; one operation in flight, SETTLE cycles per product.
module mult_share_arbiter #(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               st, nxt;
  logic [1:0]           vld, rdy;
  logic [1:0][N-1:0]    m_in, q_in;
  logic                 ptr, gnt, acc, ld_p;
  logic [3:0]           cnt;
  logic [N-1:0]         m_r, q_r;
  logic [2*N-1:0]       p_r;
  logic                 id_r;

  assign vld  = {bus.req1_valid, bus.req0_valid};
  assign m_in = {bus.req1_m, bus.req0_m};
  assign q_in = {bus.req1_q, bus.req0_q};

  // Contention goes to the pointer; otherwise the sole valid requester wins.
  assign gnt = (&vld) ? ptr : vld[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nxt;
  end

  always_comb begin
    nxt  = st;
    rdy  = '0;
    acc  = 1'b0;
    ld_p = 1'b0;
    case (st)
      IDLE: if (|vld) begin
        rdy[gnt] = 1'b1;
        acc      = 1'b1;
        nxt      = CALC;
      end
      CALC: if (cnt == '0) begin
        ld_p = 1'b1;
        nxt  = DONE;
      end
      DONE: if (bus.rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= 1'b0;
      cnt  <= '0;
      m_r  <= '0;
      q_r  <= '0;
      p_r  <= '0;
      id_r <= 1'b0;
    end else begin
      if (acc) begin
        m_r  <= m_in[gnt];
        q_r  <= q_in[gnt];
        id_r <= gnt;
        ptr  <= ~gnt;
        cnt  <= 4'(SETTLE - 1);
      end else if (st == CALC && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (ld_p) p_r <= bus.mult_p;
    end
  end

  // Ready is gated by reset so no handshake can be seen while held in reset.
  assign bus.req0_ready = rdy[0] & rst_n;
  assign bus.req1_ready = rdy[1] & rst_n;
  assign bus.mult_m     = m_r;
  assign bus.mult_q     = q_r;
  assign bus.rsp_valid  = (st == DONE);
  assign bus.rsp_id     = id_r;
  assign bus.rsp_p      = p_r;
endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand bit width; the product width is 2N.
REQ-002 The block SHALL have parameter SETTLE, default 1, giving the number of cycles allowed for the multiplier array to settle; legal values are 1 to 15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports req0_valid (input, 1 bit) and req0_ready (output, 1 bit): the requester-0 handshake.
REQ-006 The block SHALL have ports req0_m and req0_q, both input, N bits: the requester-0 operands.
REQ-007 The block SHALL have ports req1_valid (input, 1 bit), req1_ready (output, 1 bit), req1_m (input, N bits) and req1_q (input, N bits): the same set for requester 1.
REQ-008 The block SHALL have port mult_m, output, N bits: the registered operand m driven to an external N-bit array multiplier.
REQ-009 The block SHALL have port mult_q, output, N bits: the registered operand q driven to the external multiplier.
REQ-010 The block SHALL have port mult_p, input, 2N bits: the combinational product returned from the external multiplier.
REQ-011 The block SHALL have ports rsp_valid (output, 1 bit) and rsp_ready (input, 1 bit): the response handshake.
REQ-012 The block SHALL have port rsp_id, output, 1 bit: the index of the requester that owns the current response.
REQ-013 The block SHALL have port rsp_p, output, 2N bits: the registered product.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, CALC and DONE, one operation in flight at a time.
REQ-015 In IDLE, the block SHALL assert reqX_ready combinationally only for the granted requester, and only when that requester's reqX_valid is 1; all other ready signals SHALL be 0.
REQ-016 In CALC and DONE, both req0_ready and req1_ready SHALL be 0.
REQ-017 Arbitration SHALL be round-robin using a 1-bit priority pointer:
- a sole valid requester wins;
- when both are valid, the pointer's requester wins;
- after each accept, the pointer SHALL move to the other requester.
REQ-018 On accept (valid and ready both 1 in IDLE), the block SHALL:
- register the winner's operands into mult_m and mult_q;
- register the winner's index into rsp_id;
- load the settle counter with SETTLE-1;
- move to CALC.
REQ-019 In CALC, the block SHALL decrement the counter each cycle; in the cycle the counter reaches 0, it SHALL register mult_p into rsp_p and move to DONE.
REQ-020 rsp_valid SHALL be 1 exactly while in DONE, and rsp_p and rsp_id SHALL stay stable while rsp_valid is 1.
REQ-021 In DONE, the block SHALL move to IDLE on the cycle rsp_valid and rsp_ready are both 1; otherwise it SHALL hold DONE indefinitely (backpressure).
REQ-022 Latency SHALL be as follows:
- for an accept in cycle T, rsp_valid first asserts in cycle T+SETTLE+1;
- a new accept is possible no earlier than the cycle after the response handshake;
- minimum spacing between accepts is therefore SETTLE+2 cycles.
REQ-023 mult_m and mult_q SHALL keep their last values outside CALC; rsp_p SHALL keep its last value after the handshake.
REQ-024 A request whose valid drops before it is accepted SHALL be ignored, with no state change.
REQ-025 The block SHALL perform no arithmetic itself: rsp_p equals mult_p sampled exactly as in REQ-019, with full 2N-bit width and no truncation.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force:
- state to IDLE;
- the priority pointer to 0 (requester 0);
- the counter, mult_m, mult_q, rsp_p and rsp_id to 0;
- rsp_valid to 0.
REQ-027 A reset asserted during CALC or DONE SHALL abandon the operation; no response is produced for it after reset releases.
REQ-028 req0_ready and req1_ready SHALL be 0 while rst_n=0.

Verification
REQ-029 The bench SHALL cover these directed scenarios (N=4, SETTLE=1 unless stated):
- Single op: req0 with m=13, q=11 accepted in cycle T -> rsp_valid=1 in cycle T+2, rsp_p=143, rsp_id=0.
- Both requesters valid after reset: req0 with 3*5 and req1 with 15*15 held valid -> req0 served first (rsp_p=15, rsp_id=0), then req1 (rsp_p=225, rsp_id=1); a third simultaneous pair is served req0 first again.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_p and rsp_id stay stable, both ready signals stay 0, then the handshake returns the FSM to IDLE.
- SETTLE=4: m=0, q=9 -> rsp_p=0, with rsp_valid asserting in cycle T+5.
- Reset mid-CALC: rst_n pulled low -> all outputs 0 immediately and no response after release; the next request is accepted normally.
- Valid drop: req1_valid pulsed for one cycle while in DONE -> never accepted.
